// File: rtl/vga_colproc_if.sv
// Bus bundle for the VGA colour processor: video-data buffer, colour lookup,
// line-FIFO write port and the latched control inputs.
interface vga_colproc_if;
  logic        ctrl_ven;
  logic [1:0]  ctrl_cd;
  logic        ctrl_pc;
  logic [31:0] vdat_i;
  logic        vdat_valid_i;
  logic        vdat_rreq_o;
  logic        clut_req_o;
  logic [7:0]  clut_adr_o;
  logic        clut_ack_i;
  logic [23:0] clut_q_i;
  logic [23:0] rgb_o;
  logic        rgb_wreq_o;
  logic        fifo_full_i;

  modport slave (
    input  ctrl_ven, ctrl_cd, ctrl_pc, vdat_i, vdat_valid_i,
    input  clut_ack_i, clut_q_i, fifo_full_i,
    output vdat_rreq_o, clut_req_o, clut_adr_o, rgb_o, rgb_wreq_o
  );

  modport master (
    output ctrl_ven, ctrl_cd, ctrl_pc, vdat_i, vdat_valid_i,
    output clut_ack_i, clut_q_i, fifo_full_i,
    input  vdat_rreq_o, clut_req_o, clut_adr_o, rgb_o, rgb_wreq_o
  );
endinterface

// File: rtl/vga_colproc.sv
// Unpacks 32-bit video words into 24-bit pixels for the line FIFO.
// Optional macro VGA_CLUT_EN enables pseudo-colour lookup in 8bpp mode.
//
// state | meaning
// IDLE  | no word held
// EMIT  | unpacking the held word, one pixel per cycle
// CLUT  | waiting for clut_ack_i, or holding a looked-up pixel behind fifo_full_i
module vga_colproc (
  input  logic         CLK_I,
  input  logic         RST_I,
  vga_colproc_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_CLUT} state_t;

  state_t      state_q, state_d;
  logic        ven_q;
  logic [1:0]  cd_q, cd_d;
  logic        pc_q, pc_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] carry_q, carry_d;
  logic [23:0] rgb_q, rgb_d;
  logic        wreq_q, wreq_d;
  logic        req_q, req_d;
  logic [7:0]  adr_q, adr_d;
  logic [23:0] lut_q, lut_d;
  logic        lut_hold_q, lut_hold_d;

  logic        first;
  logic [1:0]  cd_eff;
  logic        pc_eff;
  logic        lut_mode;
  logic        rreq;
  logic        advance;
  logic        is_last;
  logic [1:0]  last_idx;
  logic [7:0]  cur_byte;
  logic [15:0] half;
  logic [23:0] pix;

  // Config is taken live in the enabling cycle, from the latch afterwards.
  assign first  = bus.ctrl_ven & ~ven_q;
  assign cd_eff = first ? bus.ctrl_cd : cd_q;
  assign pc_eff = first ? bus.ctrl_pc : pc_q;

`ifdef VGA_CLUT_EN
  assign lut_mode       = (cd_eff == 2'b00) & pc_eff;
  assign bus.clut_req_o = req_q;
  assign bus.clut_adr_o = adr_q;
`else
  logic unused_clut;
  assign lut_mode       = 1'b0;
  assign unused_clut    = ^{pc_eff, adr_q};
  assign bus.clut_req_o = 1'b0;
  assign bus.clut_adr_o = 8'h00;
`endif

  assign bus.rgb_o       = rgb_q;
  assign bus.rgb_wreq_o  = wreq_q;
  assign bus.vdat_rreq_o = rreq & ~RST_I;

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      2'd0:    cur_byte = word_q[31:24];
      2'd1:    cur_byte = word_q[23:16];
      2'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
    half = idx_q[0] ? word_q[15:0] : word_q[31:16];
    pix  = 24'h000000;
    last_idx = 2'd0;
    case (cd_eff)
      2'b00: begin
        pix      = {cur_byte, cur_byte, cur_byte};
        last_idx = 2'd3;
      end
      2'b01: begin
        pix      = {half[15:11], 3'b000, half[10:5], 2'b00, half[4:0], 3'b000};
        last_idx = 2'd1;
      end
      2'b10: begin
        // 24bpp: 4 pixels across 3 words, leftover bytes kept in carry_q
        case (phase_q)
          2'd0:    pix = word_q[31:8];
          2'd1:    pix = {carry_q[7:0], word_q[31:16]};
          default: pix = idx_q[0] ? word_q[23:0] : {carry_q, word_q[31:24]};
        endcase
        last_idx = (phase_q == 2'd2) ? 2'd1 : 2'd0;
      end
      default: pix = word_q[23:0];
    endcase
    is_last = (idx_q == last_idx);
  end

  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    pc_d       = pc_q;
    word_d     = word_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    carry_d    = carry_q;
    rgb_d      = rgb_q;
    wreq_d     = 1'b0;
    req_d      = req_q;
    adr_d      = adr_q;
    lut_d      = lut_q;
    lut_hold_d = lut_hold_q;
    rreq       = 1'b0;
    advance    = 1'b0;

    if (first) begin
      cd_d = bus.ctrl_cd;
      pc_d = bus.ctrl_pc;
    end

    if (!bus.ctrl_ven) begin
      state_d    = ST_IDLE;
      idx_d      = 2'd0;
      phase_d    = 2'd0;
      carry_d    = 16'h0000;
      req_d      = 1'b0;
      adr_d      = 8'h00;
      lut_hold_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.vdat_valid_i) begin
            word_d  = bus.vdat_i;
            rreq    = 1'b1;
            idx_d   = 2'd0;
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (lut_mode) begin
            req_d   = 1'b1;
            adr_d   = cur_byte;
            state_d = ST_CLUT;
          end else if (!bus.fifo_full_i) begin
            rgb_d   = pix;
            wreq_d  = 1'b1;
            advance = 1'b1;
          end
        end
        ST_CLUT: begin
          if (lut_hold_q) begin
            if (!bus.fifo_full_i) begin
              rgb_d      = lut_q;
              wreq_d     = 1'b1;
              lut_hold_d = 1'b0;
              advance    = 1'b1;
            end
          end else if (req_q && bus.clut_ack_i) begin
            req_d = 1'b0;
            if (!bus.fifo_full_i) begin
              rgb_d   = bus.clut_q_i;
              wreq_d  = 1'b1;
              advance = 1'b1;
            end else begin
              lut_d      = bus.clut_q_i;
              lut_hold_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (advance) begin
        if (is_last) begin
          idx_d = 2'd0;
          if (cd_eff == 2'b10) begin
            case (phase_q)
              2'd0: begin
                carry_d = {8'h00, word_q[7:0]};
                phase_d = 2'd1;
              end
              2'd1: begin
                carry_d = word_q[15:0];
                phase_d = 2'd2;
              end
              default: begin
                carry_d = 16'h0000;
                phase_d = 2'd0;
              end
            endcase
          end
          if (bus.vdat_valid_i) begin
            word_d  = bus.vdat_i;
            rreq    = 1'b1;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_EMIT;
        end
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      ven_q      <= 1'b0;
      cd_q       <= 2'b00;
      pc_q       <= 1'b0;
      word_q     <= 32'h0;
      idx_q      <= 2'd0;
      phase_q    <= 2'd0;
      carry_q    <= 16'h0;
      rgb_q      <= 24'h0;
      wreq_q     <= 1'b0;
      req_q      <= 1'b0;
      adr_q      <= 8'h00;
      lut_q      <= 24'h0;
      lut_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ven_q      <= bus.ctrl_ven;
      cd_q       <= cd_d;
      pc_q       <= pc_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      carry_q    <= carry_d;
      rgb_q      <= rgb_d;
      wreq_q     <= wreq_d;
      req_q      <= req_d;
      adr_q      <= adr_d;
      lut_q      <= lut_d;
      lut_hold_q <= lut_hold_d;
    end
  end

endmodule

// File: tb/tb_vga_colproc.sv
// Scoreboard bench for vga_colproc; the lookup scenarios are built only
// when VGA_CLUT_EN is defined, otherwise the grayscale fallback is checked.
module tb_vga_colproc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_colproc_if bus ();

  vga_colproc dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          rreq_cnt = 0;
  bit          pop_flag = 1'b0;
  bit          clut_seen = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] wq[$];

  always @(posedge clk) cyc++;

  // Monitor: record every written pixel and every buffer pop.
  always @(negedge clk) begin
    if (bus.rgb_wreq_o) begin
      obs_q.push_back(bus.rgb_o);
      obs_cyc.push_back(cyc);
    end
    if (bus.vdat_rreq_o) rreq_cnt++;
    if (bus.clut_req_o) clut_seen = 1'b1;
    pop_flag = bus.vdat_rreq_o;
  end

  // Show-ahead buffer model.
  always @(posedge clk) begin
    #2;
    if (pop_flag && wq.size() > 0) void'(wq.pop_front());
    pop_flag = 1'b0;
    if (wq.size() > 0) begin
      bus.vdat_i       = wq[0];
      bus.vdat_valid_i = 1'b1;
    end else begin
      bus.vdat_i       = 32'h0;
      bus.vdat_valid_i = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    wq.delete();
    pop_flag  = 1'b0;
    rreq_cnt  = 0;
    clut_seen = 1'b0;
  endtask

  task automatic start(input logic [1:0] cd, input logic pc);
    bus.ctrl_ven = 1'b0;
    tick();
    tick();
    clear_sb();
    bus.ctrl_cd  = cd;
    bus.ctrl_pc  = pc;
    bus.ctrl_ven = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int w = 0;
    while (obs_q.size() < n && w < budget) begin
      tick();
      w++;
    end
  endtask

  task automatic test_reset();
    bus.ctrl_ven    = 1'b1;
    bus.ctrl_cd     = 2'b11;
    bus.ctrl_pc     = 1'b1;
    bus.clut_ack_i  = 1'b1;
    bus.clut_q_i    = 24'hABCDEF;
    bus.fifo_full_i = 1'b0;
    rst = 1'b1;
    wq.push_back(32'h12345678);
    tick();
    tick();
    tick();
    n_total++; if (bus.rgb_o !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got=%h want=000000", bus.rgb_o); end
    n_total++; if (bus.rgb_wreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_wreq got=%b want=0", bus.rgb_wreq_o); end
    n_total++; if (bus.vdat_rreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_rreq got=%b want=0", bus.vdat_rreq_o); end
    n_total++; if (bus.clut_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_clut_req got=%b want=0", bus.clut_req_o); end
    n_total++; if (bus.clut_adr_o !== 8'h00) begin n_bad++; $display("FAIL reset_clut_adr got=%h want=00", bus.clut_adr_o); end
    bus.clut_ack_i = 1'b0;
    bus.ctrl_ven   = 1'b0;
    wq.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_32bpp();
    start(2'b11, 1'b0);
    tick();
    bus.ctrl_cd = 2'b00;  // must be ignored until the next enable
    wq.push_back(32'hAA112233); exp_q.push_back(24'h112233);
    wq.push_back(32'h00445566); exp_q.push_back(24'h445566);
    wait_obs(2, 40);
    repeat (4) tick();
    n_total++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL b32_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b32_pix%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_cyc.size() >= 2) begin
      n_total++; if (obs_cyc[1] - obs_cyc[0] != 1) begin n_bad++; $display("FAIL b32_consecutive got=%0d want=1", obs_cyc[1] - obs_cyc[0]); end
    end
    n_total++; if (rreq_cnt != 2) begin n_bad++; $display("FAIL b32_rreq got=%0d want=2", rreq_cnt); end
  endtask

  task automatic test_24bpp();
    start(2'b10, 1'b0);
    wq.push_back(32'h11223344);
    wq.push_back(32'h55667788);
    wq.push_back(32'h99AABBCC);
    wq.push_back(32'h01020304);  // starts a fresh group if the phase wrapped to 0
    exp_q.push_back(24'h112233);
    exp_q.push_back(24'h445566);
    exp_q.push_back(24'h778899);
    exp_q.push_back(24'hAABBCC);
    exp_q.push_back(24'h010203);
    wait_obs(5, 60);
    repeat (4) tick();
    n_total++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL b24_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b24_pix%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    n_total++; if (rreq_cnt != 4) begin n_bad++; $display("FAIL b24_rreq got=%0d want=4", rreq_cnt); end
  endtask

  task automatic test_16bpp_full();
    int w = 0;
    start(2'b01, 1'b0);
    wq.push_back(32'hF80007E0);
    exp_q.push_back(24'hF80000);
    exp_q.push_back(24'h00FC00);
    while (!bus.rgb_wreq_o && w < 40) begin
      tick();
      w++;
    end
    n_total++; if (w >= 40) begin n_bad++; $display("FAIL b16_first got=timeout want=wreq"); end
    bus.fifo_full_i = 1'b1;
    repeat (3) tick();
    bus.fifo_full_i = 1'b0;
    repeat (8) tick();
    n_total++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL b16_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b16_pix%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_cyc.size() >= 2) begin
      n_total++; if (obs_cyc[1] - obs_cyc[0] != 4) begin n_bad++; $display("FAIL b16_gap got=%0d want=4", obs_cyc[1] - obs_cyc[0]); end
    end
  endtask

  task automatic test_gray8();
`ifdef VGA_CLUT_EN
    start(2'b00, 1'b0);
`else
    start(2'b00, 1'b1);  // pc has no effect without the lookup
`endif
    wq.push_back(32'h01020304);
    wq.push_back(32'hF0E0D0C0);
    exp_q.push_back(24'h010101); exp_q.push_back(24'h020202);
    exp_q.push_back(24'h030303); exp_q.push_back(24'h040404);
    exp_q.push_back(24'hF0F0F0); exp_q.push_back(24'hE0E0E0);
    exp_q.push_back(24'hD0D0D0); exp_q.push_back(24'hC0C0C0);
    wait_obs(8, 60);
    repeat (4) tick();
    n_total++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL gray_count got=%0d want=8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gray_pix%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    n_total++; if (clut_seen !== 1'b0) begin n_bad++; $display("FAIL gray_no_clut got=%b want=0", clut_seen); end
  endtask

`ifdef VGA_CLUT_EN
  task automatic test_clut();
    logic [7:0] a;
    int w;
    start(2'b00, 1'b1);
    bus.clut_ack_i = 1'b1;  // stray ack, nothing requested
    bus.clut_q_i   = 24'h777777;
    tick();
    bus.clut_ack_i = 1'b0;
    wq.push_back(32'h01020304);
    for (int k = 0; k < 4; k++) begin
      a = 8'(k + 1);
      w = 0;
      while (!bus.clut_req_o && w < 30) begin
        tick();
        w++;
      end
      n_total++; if (w >= 30) begin n_bad++; $display("FAIL clut_req%0d got=timeout want=req", k); end
      n_total++; if (bus.clut_adr_o !== a) begin n_bad++; $display("FAIL clut_adr%0d got=%h want=%h", k, bus.clut_adr_o, a); end
      exp_q.push_back({a, ~a, 8'h5A});
      bus.clut_q_i = {bus.clut_adr_o, ~bus.clut_adr_o, 8'h5A};
      tick();
      tick();
      bus.clut_ack_i = 1'b1;
      tick();
      bus.clut_ack_i = 1'b0;
    end
    wait_obs(4, 30);
    repeat (4) tick();
    n_total++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL clut_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL clut_pix%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask
`endif

  task automatic test_flush();
    start(2'b10, 1'b0);
    wq.push_back(32'h11223344);
    exp_q.push_back(24'h112233);
    wait_obs(1, 40);
    tick();
    tick();
    bus.ctrl_ven = 1'b0;
    wq.push_back(32'h55667788);
    repeat (4) tick();
    n_total++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL flush_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_total++; if (obs_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL flush_w0 got=%h want=%h", obs_q[0], exp_q[0]); end
    end
    n_total++; if (rreq_cnt != 1) begin n_bad++; $display("FAIL flush_rreq got=%0d want=1", rreq_cnt); end
    wq.delete();
    pop_flag = 1'b0;
    tick();
    bus.ctrl_ven = 1'b1;
    wq.push_back(32'hDDEEFF00);
    exp_q.push_back(24'hDDEEFF);
    wait_obs(2, 40);
    repeat (3) tick();
    n_total++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL flush_reen_count got=%0d want=2", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      n_total++; if (obs_q[1] !== exp_q[1]) begin n_bad++; $display("FAIL flush_reen_pix got=%h want=%h", obs_q[1], exp_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int want_n;
`ifdef VGA_CLUT_EN
    start(2'b00, 1'b1);
    wq.push_back(32'h01020304);
    while (!bus.clut_req_o && w < 30) begin
      tick();
      w++;
    end
    want_n = 0;
`else
    start(2'b00, 1'b0);
    wq.push_back(32'h01020304);
    while (!bus.rgb_wreq_o && w < 30) begin
      tick();
      w++;
    end
    want_n = 1;
`endif
    n_total++; if (w >= 30) begin n_bad++; $display("FAIL rmid_trigger got=timeout want=activity"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.clut_ack_i = 1'b1;
    bus.clut_q_i   = 24'h123456;
    n_total++; if (bus.clut_req_o !== 1'b0) begin n_bad++; $display("FAIL rmid_req got=%b want=0", bus.clut_req_o); end
    tick();
    bus.clut_ack_i = 1'b0;
    n_total++; if (bus.rgb_wreq_o !== 1'b0) begin n_bad++; $display("FAIL rmid_wreq got=%b want=0", bus.rgb_wreq_o); end
    n_total++; if (bus.rgb_o !== 24'h0) begin n_bad++; $display("FAIL rmid_rgb got=%h want=000000", bus.rgb_o); end
    n_total++; if (bus.clut_adr_o !== 8'h00) begin n_bad++; $display("FAIL rmid_adr got=%h want=00", bus.clut_adr_o); end
    repeat (6) tick();
    n_total++; if (obs_q.size() != want_n) begin n_bad++; $display("FAIL rmid_count got=%0d want=%0d", obs_q.size(), want_n); end
    if (want_n == 1 && obs_q.size() >= 1) begin
      n_total++; if (obs_q[0] !== 24'h010101) begin n_bad++; $display("FAIL rmid_pix got=%h want=010101", obs_q[0]); end
    end
  endtask

  initial begin
    bus.ctrl_ven     = 1'b0;
    bus.ctrl_cd      = 2'b00;
    bus.ctrl_pc      = 1'b0;
    bus.vdat_i       = 32'h0;
    bus.vdat_valid_i = 1'b0;
    bus.clut_ack_i   = 1'b0;
    bus.clut_q_i     = 24'h0;
    bus.fifo_full_i  = 1'b0;
    test_reset();
    test_32bpp();
    test_24bpp();
    test_16bpp_full();
    test_gray8();
`ifdef VGA_CLUT_EN
    test_clut();
`endif
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_colproc.md
VGA_COLPROC -- requirements
Module: vga_colproc

Interface
REQ-001 CLK_I  in  1  single clock (wishbone clock domain); all state updates on its rising edge.
REQ-002 RST_I  in  1  reset, synchronous, active-high.
REQ-003 ctrl_ven  in  1  video enable; low = synchronous flush.
REQ-004 ctrl_cd  in  2  colour depth: 00=8bpp, 01=16bpp, 10=24bpp, 11=32bpp.
REQ-005 ctrl_pc  in  1  pseudo-colour select; meaningful in 8bpp only.
REQ-006 vdat_i  in  32  head word of the video-data buffer (show-ahead).
REQ-007 vdat_valid_i  in  1  vdat_i holds a valid word.
REQ-008 vdat_rreq_o  out  1  pops vdat_i; high only in the cycle the word is captured.
REQ-009 clut_req_o  out  1  colour-lookup request.
REQ-010 clut_adr_o  out  8  colour-lookup index.
REQ-011 clut_ack_i  in  1  lookup complete; clut_q_i valid.
REQ-012 clut_q_i  in  24  lookup result {R,G,B}.
REQ-013 rgb_o  out  24  pixel {R[23:16],G[15:8],B[7:0]} for the line FIFO.
REQ-014 rgb_wreq_o  out  1  line-FIFO write strobe, one pixel per high cycle.
REQ-015 fifo_full_i  in  1  line FIFO full (write side).

Function
REQ-016 ctrl_cd and ctrl_pc SHALL be latched in the first cycle ctrl_ven is high after being low or after reset; later changes are ignored until the next enable.
REQ-017 States: IDLE (no word held), EMIT (unpacking the held word), CLUT (waiting for clut_ack_i).
REQ-018 In IDLE or on the last pixel of a word, the block SHALL capture vdat_i and assert vdat_rreq_o for that cycle when vdat_valid_i=1.
REQ-019 Byte order is MSB-first: 8bpp = pixels [31:24],[23:16],[15:8],[7:0]; 16bpp = [31:16],[15:0]; 32bpp = [23:0], with [31:24] discarded.
REQ-020 24bpp packs 4 pixels in 3 words: W0=R0G0B0R1, W1=G1B1R2G2, W2=B2R3G3B3. A 2-bit phase counter SHALL track this and wrap 2->0; leftover bytes are held in a carry register.
REQ-021 16bpp is RGB565. Expansion: R={p[15:11],3'b0}, G={p[10:5],2'b0}, B={p[4:0],3'b0}.
REQ-022 8bpp grayscale (ctrl_pc=0): R=G=B=byte.
REQ-023 rgb_o and rgb_wreq_o SHALL be registered; the first pixel appears one cycle after word capture.
REQ-024 Throughput: at most one pixel per cycle.
REQ-025 No pixel SHALL be emitted in a cycle where fifo_full_i=1; the pixel index holds, and emission resumes the cycle after fifo_full_i falls.
REQ-026 rgb_wreq_o SHALL be a single-cycle pulse per pixel; no pixel is dropped or duplicated.
REQ-027 Buffer empty (vdat_valid_i=0) at a word boundary: go to or stay in IDLE, rgb_wreq_o=0.
REQ-028 ctrl_ven=0 SHALL, in the same edge, force IDLE, clear the phase counter, carry register and pixel index, and drive rgb_wreq_o=0, vdat_rreq_o=0 and clut_req_o=0.

Reset
REQ-029 While RST_I=1 at the clock edge: state=IDLE, rgb_o=0, rgb_wreq_o=0, vdat_rreq_o=0, clut_req_o=0, clut_adr_o=0, phase=0, latched cd=00 and pc=0.
REQ-030 Reset mid-operation SHALL abandon any held word and any outstanding lookup; a clut_ack_i arriving afterwards SHALL be ignored.

Configuration
REQ-031 Macro VGA_CLUT_EN defined: 8bpp with ctrl_pc=1 enters CLUT per pixel and holds clut_req_o=1 with clut_adr_o=byte until clut_ack_i. It then writes clut_q_i as the pixel in the next cycle (subject to REQ-025). clut_ack_i without a request is ignored.
REQ-032 VGA_CLUT_EN undefined: ctrl_pc is ignored, 8bpp is always grayscale, and clut_req_o and clut_adr_o are constant 0.

Verification
REQ-033 cd=11, words 0xAA112233 and 0x00445566 valid back-to-back, fifo_full_i=0 -> rgb_o 0x112233 then 0x445566 on consecutive cycles, two vdat_rreq_o pulses.
REQ-034 cd=10, words 0x11223344, 0x55667788, 0x99AABBCC -> pixels 0x112233, 0x445566, 0x778899, 0xAABBCC; phase returns to 0.
REQ-035 cd=01, word 0xF800_07E0 -> pixels 0xF80000, 0x00FC00; fifo_full_i high for 3 cycles between them -> exactly 2 wreq pulses, second 4 cycles late.
REQ-036 VGA_CLUT_EN, cd=00, pc=1, word 0x01020304, clut_ack_i 2 cycles after each request -> clut_adr_o 0x01..0x04 in order, four writes of clut_q_i.
REQ-037 cd=10, ctrl_ven dropped after W0 -> no further wreq. Re-enable with W0' = 0xDDEEFF00 -> first pixel 0xDDEEFF (phase reset).
REQ-038 RST_I pulsed while clut_req_o=1, then clut_ack_i=1 -> clut_req_o=0 next cycle, no wreq, all outputs at reset values.
